// File: rtl/nubus_cpld_seq_if.sv
// Bus-side and FPGA-side signal bundle for the NuBus arbitration/direction sequencer.
// The slave modport is the sequencer's view; the master modport is the driving side.
interface nubus_cpld_seq_if #(parameter int ID_W = 4);
  logic            nubus_oe;
  logic            master_req;
  logic            tmoen;
  logic [ID_W-1:0] id_n_5v;
  logic [ID_W-1:0] arb_n_5v;
  logic            start_n_5v;
  logic            ack_n_5v;
  logic            rqst_o_n;
  logic [ID_W-1:0] arb_o_n;
  logic            grant;
  logic            master_dir;
  logic            start_oe_n;
  logic            ctl_oe_n;
  logic            arb_timeout;

  modport slave (
    input  nubus_oe, master_req, tmoen, id_n_5v, arb_n_5v, start_n_5v, ack_n_5v,
    output rqst_o_n, arb_o_n, grant, master_dir, start_oe_n, ctl_oe_n, arb_timeout
  );

  modport master (
    output nubus_oe, master_req, tmoen, id_n_5v, arb_n_5v, start_n_5v, ack_n_5v,
    input  rqst_o_n, arb_o_n, grant, master_dir, start_oe_n, ctl_oe_n, arb_timeout
  );
endinterface

// File: rtl/nubus_cpld_seq.sv
// NuBus arbitration sequencer with direction control and driver dead-time insertion.
// Define NUBUS_ARB_TIMEOUT_EN to abort arbitration after TIMEOUT_CYCLES clocks.
module nubus_cpld_seq #(
  parameter int ID_W           = 4,
  parameter int ARB_SETTLE     = 2,
  parameter int TURN_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk_n_5v,
  input logic reset_n_5v,
  nubus_cpld_seq_if.slave bus
);

  generate
    if (ARB_SETTLE < 1 || TURN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_err
      $error("nubus_cpld_seq: ARB_SETTLE, TURN_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end
  endgenerate

  localparam int CMAX = (ARB_SETTLE > TURN_CYCLES) ? ARB_SETTLE : TURN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TMW  = $clog2(TURN_CYCLES + 1);
  localparam logic [CW-1:0]  SETTLE_LD = CW'(ARB_SETTLE - 1);
  localparam logic [CW-1:0]  TURN_LD   = CW'(TURN_CYCLES - 1);
  localparam logic [TMW-1:0] TM_FULL   = TMW'(TURN_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOST, S_WAIT, S_TURN, S_OWNER} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TMW-1:0] tm_cnt_q, tm_cnt_d;
  logic           ctl_en_q, ctl_en_d;
  logic           master_dir_q, master_dir_d;
  logic           bus_busy_q, bus_busy_d;
  logic           in_arb, dir_chg, req_ok;
  logic [ID_W-1:0] arb_drv;

  // ACK wins over START so a single-cycle transaction never marks the bus busy.
  always_comb begin
    bus_busy_d = bus_busy_q;
    if (!bus.ack_n_5v)        bus_busy_d = 1'b0;
    else if (!bus.start_n_5v) bus_busy_d = 1'b1;
  end

  // Back off bit k once the bus shows a higher bit we are not asserting ourselves.
  always_comb begin
    logic blk;
    arb_drv = '1;
    blk     = 1'b0;
    for (int k = 0; k < ID_W; k++) begin
      blk = 1'b0;
      for (int j = k + 1; j < ID_W; j++)
        if (!bus.arb_n_5v[j] && bus.id_n_5v[j]) blk = 1'b1;
      if (!bus.id_n_5v[k] && !blk) arb_drv[k] = 1'b0;
    end
  end

  assign in_arb = (state_q == S_ARB) || (state_q == S_LOST) || (state_q == S_WAIT);

`ifdef NUBUS_ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           to_hit, timeout_q, block_q, block_d;

  assign to_hit = in_arb && (to_cnt_q == TO_LAST);
  assign req_ok = !block_q;

  // After an abort, master_req must drop before another attempt is allowed.
  always_comb begin
    to_cnt_d = in_arb ? to_cnt_q + TOW'(1) : '0;
    block_d  = (block_q && bus.master_req) || (to_hit && !bus.nubus_oe);
  end

  always_ff @(posedge clk_n_5v or negedge reset_n_5v) begin
    if (!reset_n_5v) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      block_q   <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= to_hit && !bus.nubus_oe;
      block_q   <= block_d;
    end
  end

  assign bus.arb_timeout = timeout_q;
`else
  assign req_ok          = 1'b1;
  assign bus.arb_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.nubus_oe) begin
      state_d = S_IDLE;
`ifdef NUBUS_ARB_TIMEOUT_EN
    end else if (to_hit) begin
      state_d = S_IDLE;
`endif
    end else if (in_arb && !bus.master_req) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:
          if (bus.master_req && req_ok) begin
            state_d = S_ARB;
            cnt_d   = SETTLE_LD;
          end
        S_ARB:
          if (cnt_q == '0) state_d = (bus.arb_n_5v == bus.id_n_5v) ? S_WAIT : S_LOST;
          else             cnt_d   = cnt_q - CW'(1);
        S_LOST:
          if (!bus.start_n_5v) begin
            state_d = S_ARB;
            cnt_d   = SETTLE_LD;
          end
        S_WAIT:
          if (!bus_busy_d && bus.start_n_5v) begin
            state_d = S_TURN;
            cnt_d   = TURN_LD;
          end
        S_TURN:
          if (cnt_q == '0) state_d = S_OWNER;
          else             cnt_d   = cnt_q - CW'(1);
        S_OWNER:
          if (!bus.master_req && !bus_busy_d) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign master_dir_d = (state_d == S_TURN) || (state_d == S_OWNER);
  assign dir_chg      = master_dir_d ^ master_dir_q;

  // TM/ACK enable needs TURN_CYCLES clean tmoen samples since the last direction flip.
  always_comb begin
    tm_cnt_d = tm_cnt_q;
    ctl_en_d = 1'b0;
    if (!bus.tmoen || dir_chg || bus.nubus_oe) tm_cnt_d = '0;
    else if (tm_cnt_q == TM_FULL)               ctl_en_d = 1'b1;
    else                                        tm_cnt_d = tm_cnt_q + TMW'(1);
  end

  always_ff @(posedge clk_n_5v or negedge reset_n_5v) begin
    if (!reset_n_5v) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tm_cnt_q     <= '0;
      ctl_en_q     <= 1'b0;
      master_dir_q <= 1'b0;
      bus_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tm_cnt_q     <= tm_cnt_d;
      ctl_en_q     <= ctl_en_d;
      master_dir_q <= master_dir_d;
      bus_busy_q   <= bus_busy_d;
    end
  end

  assign bus.rqst_o_n   = bus.nubus_oe ||
                          !(in_arb || (state_q == S_OWNER && bus.master_req));
  assign bus.arb_o_n    = (state_q == S_ARB && !bus.nubus_oe) ? arb_drv : '1;
  assign bus.grant      = (state_q == S_OWNER);
  assign bus.master_dir = master_dir_q;
  assign bus.start_oe_n = bus.nubus_oe || (state_q != S_OWNER);
  assign bus.ctl_oe_n   = bus.nubus_oe || !ctl_en_q;

endmodule

// File: doc/nubus_cpld_seq.md
Name: nubus_cpld_seq

Overview:
- Parametrised, clocked successor to the NuBus CPLD glue. Sits between the 5 V NuBus transceivers and the FPGA.
- Runs the NuBus arbitration sequence (RQST, ARB drive, settle, win/lose, wait for bus free) and owns direction control for START and the TM/ACK group.
- Inserts programmable dead-time on every driver turn-on, so the 5 V transceivers never fight on the bus.

Parameters:
- ID_W, 4: width of the card ID and ARB lines.
- ARB_SETTLE, 2: clocks the ARB lines are driven before the win/lose compare (>=1).
- TURN_CYCLES, 1: dead-time clocks, all drivers off, before any driver turn-on (>=1).
- TIMEOUT_CYCLES, 255: arbitration timeout limit; used only with NUBUS_ARB_TIMEOUT_EN.

Ports:
- clk_n_5v  in  1  NuBus clock; all state updates on its rising edge.
- reset_n_5v  in  1  Asynchronous, active-low reset.
- nubus_oe  in  1  1 = all 5 V drivers disabled.
- master_req  in  1  FPGA level request for bus ownership.
- tmoen  in  1  FPGA requests drive of the TM/ACK group.
- id_n_5v  in  ID_W  Card ID, active low.
- arb_n_5v  in  ID_W  Sampled ARB lines, wired-OR, active low.
- start_n_5v  in  1  Bus START, active low.
- ack_n_5v  in  1  Bus ACK, active low.
- rqst_o_n  out  1  RQST drive, active low (open-collector buffer).
- arb_o_n  out  ID_W  ARB drive, active low.
- grant  out  1  1 = this card owns the bus.
- master_dir  out  1  Registered direction; 1 = master.
- start_oe_n  out  1  START driver enable, active low.
- ctl_oe_n  out  1  TM/ACK group driver enable, active low.
- arb_timeout  out  1  One-cycle pulse when arbitration is aborted.

Behaviour:
- Reset values: rqst_o_n=1, arb_o_n=all 1, grant=0, master_dir=0, start_oe_n=1, ctl_oe_n=1, arb_timeout=0. FSM=IDLE, counters=0, bus_busy=0.
- bus_busy register:
  - set when start_n_5v=0 and ack_n_5v=1;
  - cleared when ack_n_5v=0;
  - start_n_5v=0 and ack_n_5v=0 in the same cycle (single-cycle transaction) leaves it 0.
- ARB drive (combinational, active only in ARB): drive bit k low iff ~id_n_5v[k]=1 and there is no j>k with ~arb_n_5v[j]=1 and ~id_n_5v[j]=0. In all other states arb_o_n is all 1.
- FSM states:
  - IDLE: leave when master_req=1 → ARB, with the settle counter loaded.
  - ARB: rqst_o_n=0. Count ARB_SETTLE clocks, then compare. If arb_n_5v==id_n_5v → WAIT_BUS, else → LOST.
  - LOST: rqst_o_n=0, ARB drive off. Wait for start_n_5v=0 (winner's START), then → ARB.
  - WAIT_BUS: rqst_o_n=0. When bus_busy=0 and start_n_5v=1 → TURN.
  - TURN: all drivers off for TURN_CYCLES clocks, then → OWNER. master_dir becomes 1 on TURN entry.
  - OWNER: grant=1, start_oe_n=0. rqst_o_n=0 while master_req=1. When master_req=0 and bus_busy=0 → IDLE, with master_dir=0 and grant=0 on the same edge.
- master_req dropping in ARB, LOST or WAIT_BUS: → IDLE next clock, rqst_o_n released.
- ctl_oe_n:
  - goes 0 only after tmoen has been 1 for TURN_CYCLES consecutive clocks with master_dir stable;
  - returns to 1 on the clock after tmoen=0 or after any master_dir change;
  - a master_dir change restarts the turn counter.
- nubus_oe=1:
  - forces every enable/drive output inactive combinationally (rqst_o_n, arb_o_n, start_oe_n, ctl_oe_n = 1);
  - synchronously returns the FSM to IDLE with grant=0;
  - master_req is ignored while it is held.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). No ARB or RQST glitch low after release.
- Latency: master_req↑ to rqst_o_n↓ is 1 clock. Best-case master_req↑ to grant is 1 + ARB_SETTLE + 1 + TURN_CYCLES clocks.

Optional Feature:
- Macro: NUBUS_ARB_TIMEOUT_EN.
- Defined: a counter runs while in ARB, LOST or WAIT_BUS and clears in any other state. When it reaches TIMEOUT_CYCLES:
  - arb_timeout pulses 1 for one clock;
  - the FSM goes to IDLE, releasing RQST and ARB;
  - re-entry to ARB requires master_req to go 0 then 1 again.
- Undefined: no counter; arb_timeout is tied 0; the FSM waits indefinitely.

Test Plan:
- Uncontested win: id_n=4'b0101, arb_n follows own drive, master_req↑ at cycle 0 → rqst_o_n=0 at cycle 1, grant=1 at cycle 5 (defaults), start_oe_n=0 with grant.
- Lost arbitration: id_n=4'b1110, bus arb_n=4'b0111 → arb_o_n releases bits 0–2; FSM goes to LOST, rqst_o_n stays 0; START pulse → ARB re-entered; won on the next try.
- Bus busy: win while start seen and ack still 1 → stays in WAIT_BUS; ack_n_5v=0 → grant asserts TURN_CYCLES+1 clocks later.
- Turnaround: OWNER with tmoen=1; master_req drops and bus idle → master_dir=0; ctl_oe_n is 1 for at least TURN_CYCLES clocks before re-enabling.
- nubus_oe=1 in OWNER → all drive/enable outputs are 1 in the same cycle, grant=0 next clock. Async reset pulse in ARB → rqst_o_n=1 immediately.
- Timeout (macro on, TIMEOUT_CYCLES=8): permanent loss → arb_timeout pulse 8 clocks after ARB entry, FSM IDLE; master_req held at 1 does not restart arbitration.
